// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the 4-phase req/ack clock-domain crossing blocks.
// Used by both the transmit end and the matching receive end.
`timescale 1ns/1ps
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        SETTLE,
        IDLE,
        REQ,
        REL
    } hs_tx_state_t;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    // Settle counter must be able to hold SYNC_STAGES without wrapping.
    function automatic int settle_cnt_width(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/cdc_handshake_tx_sync_chain.sv
// Multi-flop synchronizer for one asynchronous level signal.
// Clears to 0 on reset; d appears on q after STAGES rising edges.
`timescale 1ns/1ps
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Transmit end of a 4-phase req/ack crossing: captures a word, raises req_o,
// waits for the synchronized ack to rise and fall, then pulses done.
`timescale 1ns/1ps
module cdc_handshake_tx
    import cdc_hs_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             req_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ack_i,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = settle_cnt_width(SYNC_STAGES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SYNC_STAGES);

    hs_tx_state_t     state_reg;
    logic [CNT_W-1:0] settle_cnt_reg;
    logic             req_reg;
    logic [WIDTH-1:0] data_reg;
    logic             done_reg;
    logic             ack_s;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ack_i),
        .q    (ack_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= SETTLE;
            settle_cnt_reg <= '0;
            req_reg        <= 1'b0;
            data_reg       <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                // Wait until the chain has flushed so a held-over ack is visible.
                SETTLE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                    end
                end
                IDLE: begin
                    if (in_valid && !ack_s) begin
                        data_reg  <= in_data;
                        req_reg   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        req_reg   <= 1'b0;
                        state_reg <= REL;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= SETTLE;
                end
            endcase
        end
    end

    // Decoded from flops only; ack_i never reaches an output combinationally.
    assign in_ready = (state_reg == IDLE) && !ack_s;
    assign busy     = (state_reg == REQ) || (state_reg == REL);
    assign req_o    = req_reg;
    assign data_o   = data_reg;
    assign done     = done_reg;

endmodule
